// File: rtl/gpio_handshake_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_hs_pkg
//  Purpose  : Shared types and constants for the GPIO handshake responder:
//             handshake FSM state encoding and the expected mprj_io count
//             sequence tracked by the checker.
//  Revision : 1.0  initial release
// ============================================================================
package gpio_hs_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    DELAY = 3'd2,
    ACK   = 3'd3,
    GUARD = 3'd4
  } hs_state_t;

  localparam int IDX_W   = 4;
  localparam int SEQ_LEN = 12;

  // Sequence length as an index-width value, for compares against seq_idx
  localparam logic [IDX_W-1:0] SEQ_LEN_IDX = 4'd12;

  // Firmware count pattern: 01..0A, then FF, then 00
  localparam logic [7:0] SEQ_EXP [SEQ_LEN] = '{
    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
    8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00
  };

  // Bounded table lookup; callers only act on the result when idx < SEQ_LEN
  function automatic logic [7:0] seq_exp_at(input logic [IDX_W-1:0] idx);
    if (idx < SEQ_LEN_IDX) begin
      return SEQ_EXP[idx];
    end
    return 8'h00;
  endfunction

endpackage : gpio_hs_pkg
`default_nettype wire

// File: rtl/gpio_handshake_responder_io_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : io_seq_checker
//  Purpose  : Tracks the synchronised mprj_io[7:0] count pattern. Raises a
//             sticky pass once all entries are seen in order, or a sticky fail
//             on timeout. Macro SEQ_STRICT_EN additionally fails on a held
//             out-of-order value once the sequence has started.
//  Revision : 1.0  initial release
// ============================================================================
module io_seq_checker
  import gpio_hs_pkg::*;
#(
  parameter int TIMEOUT = 25000,
  parameter int CNT_W   = 15
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [7:0]       data_i,
  output logic [IDX_W-1:0] seq_idx_o,
  output logic             pass_o,
  output logic             fail_o
);

  localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_TMO_MAX  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_tmo;
  logic [IDX_W-1:0] r_idx;
  logic             r_pass;
  logic             r_fail;

  logic w_frozen;
  logic w_match;
  logic w_last;
  logic w_tmo_hit;
  logic w_strict_fail;

  assign w_frozen  = r_pass | r_fail;
  assign w_match   = (r_idx < SEQ_LEN_IDX) && (data_i == seq_exp_at(r_idx));
  assign w_last    = w_match && (r_idx == (SEQ_LEN_IDX - 4'd1));
  assign w_tmo_hit = (r_tmo == c_TMO_LAST);

`ifdef SEQ_STRICT_EN
  logic       r_bad_q;
  logic [7:0] r_data_q;
  logic       w_bad;

  // A value is out of order when it is neither the entry just matched nor the next one
  assign w_bad = (r_idx != '0) && (r_idx < SEQ_LEN_IDX) &&
                 (data_i != seq_exp_at(r_idx - 4'd1)) &&
                 (data_i != seq_exp_at(r_idx));

  // Remember last cycle's value so a single-cycle glitch never trips the fail
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_bad_q  <= 1'b0;
      r_data_q <= 8'h00;
    end else begin
      r_bad_q  <= w_bad;
      r_data_q <= data_i;
    end
  end

  assign w_strict_fail = w_bad && r_bad_q && (data_i == r_data_q);
`else
  assign w_strict_fail = 1'b0;
`endif

  // Free-running timeout counter from reset release, saturating at TIMEOUT
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_tmo <= '0;
    end else if (r_tmo != c_TMO_MAX) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // Sequence progress and sticky verdicts; a final match beats a same-cycle timeout
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_idx  <= '0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else if (!w_frozen) begin
      if (w_match) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_last) begin
        r_pass <= 1'b1;
      end else if (w_tmo_hit || w_strict_fail) begin
        r_fail <= 1'b1;
      end
    end
  end

  assign seq_idx_o = r_idx;
  assign pass_o    = r_pass;
  assign fail_o    = r_fail;

endmodule : io_seq_checker
`default_nettype wire

// File: rtl/gpio_handshake_responder.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_handshake_responder
//  Purpose  : User-project side of the GPIO bring-up handshake. Detects the
//             firmware ready pulse on req_i, waits ACK_DELAY cycles, then
//             drives an ACK_LEN-cycle acknowledge. An independent checker
//             follows the mprj_io[7:0] count pattern. Optional macro
//             SEQ_STRICT_EN enables strict sequence ordering in the checker.
//  Revision : 1.0  initial release
// ============================================================================
module gpio_handshake_responder
  import gpio_hs_pkg::*;
#(
  parameter int ACK_DELAY = 10,
  parameter int ACK_LEN   = 10,
  parameter int TIMEOUT   = 25000,
  parameter int CNT_W     = 15
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             req_i,
  input  logic [7:0]       data_i,
  output logic             ack_o,
  output logic             ack_oe,
  output logic             busy_o,
  output logic [IDX_W-1:0] seq_idx_o,
  output logic             pass_o,
  output logic             fail_o
);

  localparam logic [CNT_W-1:0] c_DELAY_LAST = CNT_W'(ACK_DELAY - 1);
  localparam logic [CNT_W-1:0] c_ACK_LAST   = CNT_W'(ACK_LEN - 1);

  logic       r_req_s1;
  logic       r_req_s2;
  logic       r_req_d;
  logic [7:0] r_data_s1;
  logic [7:0] r_data_s2;

  hs_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ack;

  logic w_rise;
  logic w_fall;

  // Two-flop synchronisers for the asynchronous pads, plus a delayed req for edge detection
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_req_s1  <= 1'b0;
      r_req_s2  <= 1'b0;
      r_req_d   <= 1'b0;
      r_data_s1 <= 8'h00;
      r_data_s2 <= 8'h00;
    end else begin
      r_req_s1  <= req_i;
      r_req_s2  <= r_req_s1;
      r_req_d   <= r_req_s2;
      r_data_s1 <= data_i;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_rise = r_req_s2 & ~r_req_d;
  assign w_fall = ~r_req_s2 & r_req_d;

  // Handshake FSM; ack is a flop so the pad never sees state-decode glitches
  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_state <= ARMED;
          end
        end
        ARMED: begin
          if (w_fall) begin
            r_state <= DELAY;
            r_cnt   <= '0;
          end
        end
        DELAY: begin
          if (r_cnt == c_DELAY_LAST) begin
            r_state <= ACK;
            r_cnt   <= '0;
            r_ack   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ACK: begin
          if (r_cnt == c_ACK_LAST) begin
            r_state <= GUARD;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GUARD: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o  = r_ack;
  assign ack_oe = r_ack;
  assign busy_o = (r_state != IDLE);

  io_seq_checker #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_checker (
    .clock     (clock),
    .resetb    (resetb),
    .data_i    (r_data_s2),
    .seq_idx_o (seq_idx_o),
    .pass_o    (pass_o),
    .fail_o    (fail_o)
  );

endmodule : gpio_handshake_responder
`default_nettype wire

// File: tb/tb_gpio_handshake_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_handshake_responder
//  Purpose  : Self-checking bench for gpio_handshake_responder. Directed
//             handshake / sequence / timeout scenarios followed by random
//             traffic, all compared every cycle against a schedule-based
//             reference model of the handshake and sequence rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpio_handshake_responder;

  localparam int TB_ACK_DELAY = 10;
  localparam int TB_ACK_LEN   = 10;
  localparam int TB_TIMEOUT   = 400;
  localparam int TB_LATENCY   = TB_ACK_DELAY + 3;

  localparam logic [7:0] EXP [12] = '{
    8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
    8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00
  };

  logic       clock;
  logic       resetb;
  logic       req_i;
  logic [7:0] data_i;
  logic       ack_o;
  logic       ack_oe;
  logic       busy_o;
  logic [3:0] seq_idx_o;
  logic       pass_o;
  logic       fail_o;

  int n_checks = 0;
  int n_errors = 0;

  gpio_handshake_responder #(
    .ACK_DELAY (TB_ACK_DELAY),
    .ACK_LEN   (TB_ACK_LEN),
    .TIMEOUT   (TB_TIMEOUT),
    .CNT_W     (15)
  ) dut (
    .clock     (clock),
    .resetb    (resetb),
    .req_i     (req_i),
    .data_i    (data_i),
    .ack_o     (ack_o),
    .ack_oe    (ack_oe),
    .busy_o    (busy_o),
    .seq_idx_o (seq_idx_o),
    .pass_o    (pass_o),
    .fail_o    (fail_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish (got running, required finished)");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Pad samples pass through two sync stages; the handshake is modelled as
  // an acknowledge window scheduled from the edge at which the fall is seen.
  logic       m_rs1, m_rs2, m_rd;
  logic [7:0] m_ds1, m_ds2;
  bit         m_armed, m_busy, m_ack;
  int         m_fall_at;
  int         m_edge = 0;
  int         m_cyc;
  int         m_idx;
  bit         m_pass, m_fail;
  bit         m_prev_bad;
  logic [7:0] m_prev_data;

  task automatic model_step();
    bit rise, fall, bad, strict_hit;
    m_edge++;
    if (!resetb) begin
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ds1 = 0; m_ds2 = 0;
      m_armed = 0; m_busy = 0; m_ack = 0; m_fall_at = -1000;
      m_cyc = 0; m_idx = 0; m_pass = 0; m_fail = 0;
      m_prev_bad = 0; m_prev_data = 0;
    end else begin
      rise = m_rs2 && !m_rd;
      fall = !m_rs2 && m_rd;
      if (rise && !m_busy) m_armed = 1;
      else if (fall && m_armed) begin
        m_armed   = 0;
        m_fall_at = m_edge;
      end
      m_ack  = (m_edge >= m_fall_at + TB_ACK_DELAY) &&
               (m_edge <  m_fall_at + TB_ACK_DELAY + TB_ACK_LEN);
      m_busy = m_armed || ((m_edge >= m_fall_at) &&
               (m_edge <= m_fall_at + TB_ACK_DELAY + TB_ACK_LEN));

      m_cyc++;
      bad = 0;
      strict_hit = 0;
`ifdef SEQ_STRICT_EN
      if (m_idx >= 1 && m_idx < 12)
        bad = (m_ds2 != EXP[m_idx-1]) && (m_ds2 != EXP[m_idx]);
      strict_hit = bad && m_prev_bad && (m_ds2 == m_prev_data);
`endif
      m_prev_bad  = bad;
      m_prev_data = m_ds2;
      if (!m_pass && !m_fail) begin
        if (m_idx < 12 && m_ds2 == EXP[m_idx]) m_idx++;
        if (m_idx == 12) m_pass = 1;
        else if (m_cyc >= TB_TIMEOUT || strict_hit) m_fail = 1;
      end

      m_rd  = m_rs2; m_rs2 = m_rs1; m_rs1 = req_i;
      m_ds2 = m_ds1; m_ds1 = data_i;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("ack_o",   ack_o,     m_ack);
    check("ack_oe",  ack_oe,    m_ack);
    check("busy_o",  busy_o,    m_busy);
    check("seq_idx", seq_idx_o, m_idx);
    check("pass_o",  pass_o,    m_pass);
    check("fail_o",  fail_o,    m_fail);
  endtask

  task automatic do_reset(input int n);
    resetb = 1'b0;
    repeat (n) tick();
    resetb = 1'b1;
  endtask

  // Pulse req, measure cycles from pad fall to ack, and ack length.
  // rerise_at>0 pulses req again while ack is high.
  task automatic handshake(input int rerise_at, output int lat, output int len);
    req_i = 1'b1;
    repeat (5) tick();
    req_i = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ack_o && lat < 100);
    len = 0;
    while (ack_o && len < 100) begin
      len++;
      if (rerise_at > 0 && len == rerise_at)     req_i = 1'b1;
      if (rerise_at > 0 && len == rerise_at + 3) req_i = 1'b0;
      tick();
    end
    check("busy_in_guard", busy_o, 1);
    tick();
    check("busy_after_guard", busy_o, 0);
  endtask

  initial begin
    int lat, len, c;
    resetb = 1'b0;
    req_i  = 1'b0;
    data_i = 8'h00;

    // Reset held with req toggling: everything stays low
    for (int i = 0; i < 10; i++) begin
      req_i = 1'($urandom);
      tick();
      check("reset_outs", {ack_o, ack_oe, busy_o, seq_idx_o, pass_o, fail_o}, 0);
    end
    req_i  = 1'b0;
    resetb = 1'b1;
    repeat (3) tick();

    // Basic handshake latency and length
    handshake(0, lat, len);
    check("ack_latency", lat, TB_LATENCY);
    check("ack_length",  len, TB_ACK_LEN);

    // Full sequence with junk between entries
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      data_i = EXP[i];
      repeat (20) tick();
`ifndef SEQ_STRICT_EN
      check("seq_step", seq_idx_o, i + 1);
`endif
      if (i < 11) begin
        data_i = 8'h55;
        repeat (8) tick();
      end
    end
    repeat (3) tick();
`ifdef SEQ_STRICT_EN
    check("strict_fail", fail_o, 1);
    check("strict_idx",  seq_idx_o, 1);
`else
    check("seq_pass", pass_o, 1);
    check("seq_nofail", fail_o, 0);
`endif

    // Timeout with the pattern stalled at 05
    do_reset(1);
    c = 0;
    for (int i = 0; i < 5; i++) begin
      data_i = EXP[i];
      repeat (4) begin tick(); c++; end
    end
    while (!fail_o && c < 600) begin
      tick();
      c++;
    end
    check("tmo_cycle", c, TB_TIMEOUT);
    check("tmo_idx",   seq_idx_o, 5);
    check("tmo_nopass", pass_o, 0);

    // Final 00 matched on the exact timeout cycle: pass wins
    do_reset(1);
    c = 0;
    for (int i = 0; i < 11; i++) begin
      data_i = EXP[i];
      repeat (3) begin tick(); c++; end
    end
    while (c < TB_TIMEOUT - 3) begin
      tick();
      c++;
    end
    data_i = 8'h00;
    repeat (2) begin tick(); c++; end
    check("race_before", pass_o, 0);
    tick();
    c++;
    check("race_pass", pass_o, 1);
    check("race_nofail", fail_o, 0);

    // Reset during the 4th ack cycle, then a clean handshake
    req_i = 1'b1;
    repeat (5) tick();
    req_i = 1'b0;
    c = 0;
    while (!ack_o && c < 100) begin
      tick();
      c++;
    end
    repeat (3) tick();
    resetb = 1'b0;
    tick();
    check("midrst_ack",  ack_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_idx",  seq_idx_o, 0);
    resetb = 1'b1;
    repeat (3) tick();
    handshake(0, lat, len);
    check("post_rst_latency", lat, TB_LATENCY);
    check("post_rst_length",  len, TB_ACK_LEN);

    // Second req pulse during ack does not stretch it; a later pulse works
    handshake(2, lat, len);
    check("rerise_length", len, TB_ACK_LEN);
    repeat (3) tick();
    handshake(0, lat, len);
    check("second_latency", lat, TB_LATENCY);
    check("second_length",  len, TB_ACK_LEN);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) req_i = ~req_i;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       data_i = 8'($urandom);
          1:       data_i = EXP[$urandom_range(0, 11)];
          default: data_i = (m_idx < 12) ? EXP[m_idx] : 8'h00;
        endcase
      end
      resetb = ($urandom_range(0, 299) != 0);
      tick();
    end
    resetb = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_gpio_handshake_responder
`default_nettype wire
